fetch_controller: RTL and testbench

- Sequences the instruction-fetch stage of the pipelined core. Each cycle it drives the PC load enable and the one-hot PC-source select.
- Generates the IF/ID and ID/EX pipeline-register enables and flushes in response to redirects, load-use hazards, memory busy and halt.
- Sits beside instruction_fetch. The datapath computes the branch and register targets; this block only decides which target is used and when.

---
 rtl/fetch_pkg.sv | 66 ++++++
 rtl/fetch_perf_counters.sv | 33 +++
 rtl/fetch_controller.sv | 128 ++++++++++++
 tb/tb_fetch_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The control bundle is kept as one packed struct so every output
// combination the controller can produce is named in a single place.
package fetch_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // One-hot PC-source selects.
  localparam logic [3:0] BSEL_ZERO   = 4'b0001;
  localparam logic [3:0] BSEL_SEQ    = 4'b0010;
  localparam logic [3:0] BSEL_BRANCH = 4'b0100;
  localparam logic [3:0] BSEL_REG    = 4'b1000;

  // Width of the INIT down-counter; holds INIT_CYCLES-1 for INIT_CYCLES up to 15.
  localparam int INIT_CNT_W = 4;

  typedef struct packed {
    logic       load_pc;
    logic [3:0] branch_sel;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       halted;
  } fetch_ctl_t;

  // Reset and INIT: force PC to zero and flush both pipeline registers.
  localparam fetch_ctl_t CTL_RESET = '{
    load_pc: 1'b1, branch_sel: BSEL_ZERO, if_id_en: 1'b0, if_id_flush: 1'b1,
    id_ex_en: 1'b0, id_ex_flush: 1'b1, halted: 1'b0};

  // Data memory busy: freeze everything, no flushes.
  localparam fetch_ctl_t CTL_FREEZE = '{
    load_pc: 1'b0, branch_sel: BSEL_SEQ, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b0, halted: 1'b0};

  // Register-indirect jump: load register target, squash IF and ID.
  localparam fetch_ctl_t CTL_REDIRECT_REG = '{
    load_pc: 1'b1, branch_sel: BSEL_REG, if_id_en: 1'b0, if_id_flush: 1'b1,
    id_ex_en: 1'b0, id_ex_flush: 1'b1, halted: 1'b0};

  // Taken branch: load branch target, squash IF and ID.
  localparam fetch_ctl_t CTL_REDIRECT_BR = '{
    load_pc: 1'b1, branch_sel: BSEL_BRANCH, if_id_en: 1'b0, if_id_flush: 1'b1,
    id_ex_en: 1'b0, id_ex_flush: 1'b1, halted: 1'b0};

  // Load-use stall or halt decode: hold PC and IF/ID, bubble into ID/EX.
  localparam fetch_ctl_t CTL_BUBBLE = '{
    load_pc: 1'b0, branch_sel: BSEL_SEQ, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b1, halted: 1'b0};

  // Normal sequential fetch.
  localparam fetch_ctl_t CTL_SEQ = '{
    load_pc: 1'b1, branch_sel: BSEL_SEQ, if_id_en: 1'b1, if_id_flush: 1'b0,
    id_ex_en: 1'b1, id_ex_flush: 1'b0, halted: 1'b0};

  // Halted: PC frozen, ID/EX keeps clocking NOPs so the back end drains.
  localparam fetch_ctl_t CTL_HALT = '{
    load_pc: 1'b0, branch_sel: BSEL_SEQ, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b1, id_ex_flush: 1'b1, halted: 1'b1};

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating performance counters for the fetch controller: stall cycles,
// applied redirects and RUN cycles. Only instantiated when the top is built
// with FETCH_PERF_CNT_EN.
module fetch_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             run_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] run_cnt
);

  // Each counter sticks at all-ones rather than wrapping, so a long run
  // never reports a misleadingly small value.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      run_cnt   <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (run_inc   && (run_cnt   != '1)) run_cnt   <= run_cnt   + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: picks the PC source and drives the IF/ID and
// ID/EX enables/flushes for redirects, load-use hazards, memory busy and halt.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush/run
// counters on extra output ports.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int INIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken_ex,
  input  logic             jump_reg_ex,
  input  logic             load_use_id,
  input  logic             mem_busy,
  input  logic             halt_id,
  input  logic             resume,
  output logic             load_pc,
  output logic [3:0]       branch_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] run_cnt
`endif
);

  localparam logic [INIT_CNT_W-1:0] INIT_LOAD = INIT_CNT_W'(INIT_CYCLES - 1);

  fetch_state_t            state;
  fetch_state_t            next_state;
  logic [INIT_CNT_W-1:0]   init_cnt;
  logic [INIT_CNT_W-1:0]   next_cnt;
  fetch_ctl_t              ctl;

  // State register; reset always re-enters INIT with a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= INIT_LOAD;
    end else begin
      state    <= next_state;
      init_cnt <= next_cnt;
    end
  end

  // Next-state and output decode; reset overrides the state so outputs are
  // correct even in the first cycle when the state register is unknown.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    ctl        = CTL_RESET;
    next_state = state;
    next_cnt   = init_cnt;
    if (!reset) begin
      case (state)
        INIT: begin
          ctl = CTL_RESET;
          if (init_cnt == '0) next_state = RUN;
          else                next_cnt   = init_cnt - 1'b1;
        end
        RUN: begin
          // Memory busy freezes the pipe and masks everything else; the
          // datapath holds its requests so they are seen again next cycle.
          if (mem_busy)             ctl = CTL_FREEZE;
          else if (jump_reg_ex)     ctl = CTL_REDIRECT_REG;
          else if (branch_taken_ex) ctl = CTL_REDIRECT_BR;
          else if (load_use_id)     ctl = CTL_BUBBLE;
          else if (halt_id) begin
            // Only reached without a redirect: a halt on the wrong path is
            // squashed instead of honoured.
            ctl        = CTL_BUBBLE;
            next_state = HALT;
          end else                  ctl = CTL_SEQ;
        end
        HALT: begin
          ctl = CTL_HALT;
          if (resume) next_state = RUN;
        end
        default: begin
          ctl        = CTL_RESET;
          next_state = INIT;
          next_cnt   = INIT_LOAD;
        end
      endcase
    end
  end

  assign load_pc     = ctl.load_pc;
  assign branch_sel  = ctl.branch_sel;
  assign if_id_en    = ctl.if_id_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_en    = ctl.id_ex_en;
  assign id_ex_flush = ctl.id_ex_flush;
  assign halted      = ctl.halted;

`ifdef FETCH_PERF_CNT_EN
  logic run_active;
  logic redirect_applied;
  logic stall_applied;

  // Events as actually applied this cycle, after RUN priority resolution.
  assign run_active       = !reset && (state == RUN);
  assign redirect_applied = run_active && !mem_busy && (jump_reg_ex || branch_taken_ex);
  assign stall_applied    = run_active &&
                            (mem_busy || (load_use_id && !jump_reg_ex && !branch_taken_ex));

  fetch_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .stall_inc (stall_applied),
    .flush_inc (redirect_applied),
    .run_inc   (run_active),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .run_cnt   (run_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by
// randomized traffic, all compared against a mode-level reference model.
// Build with FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_controller;

  localparam int TB_INIT_CYCLES = 2;
  localparam int TB_CNT_W       = 4;
  localparam int CMAX           = (1 << TB_CNT_W) - 1;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch_taken_ex = 1'b0, jump_reg_ex = 1'b0, load_use_id = 1'b0;
  logic mem_busy = 1'b0, halt_id = 1'b0, resume = 1'b0;
  logic load_pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted;
  logic [3:0] branch_sel;
`ifdef FETCH_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt, run_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode      = M_INIT;
  int m_init_left = TB_INIT_CYCLES - 1;
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_cnt_known = 1'b0;

  always #5 clk = ~clk;

  fetch_controller #(
    .INIT_CYCLES (TB_INIT_CYCLES),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken_ex (branch_taken_ex),
    .jump_reg_ex     (jump_reg_ex),
    .load_use_id     (load_use_id),
    .mem_busy        (mem_busy),
    .halt_id         (halt_id),
    .resume          (resume),
    .load_pc         (load_pc),
    .branch_sel      (branch_sel),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .run_cnt         (run_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t mode=%0d)", tag, got, exp, $time, m_mode);
    end
  endtask

  // Expected {load_pc, branch_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted}
  function automatic logic [9:0] expected_outputs();
    if (reset || m_mode == M_INIT) return {1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (m_mode == M_HALT)          return {1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    if (mem_busy)                  return {1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (jump_reg_ex)               return {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (branch_taken_ex)           return {1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (load_use_id || halt_id)    return {1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    return {1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic advance_model();
    bit redirect, stall;
    redirect = !mem_busy && (jump_reg_ex || branch_taken_ex);
    stall    = mem_busy || (load_use_id && !redirect);
    if (reset) begin
      m_mode = M_INIT; m_init_left = TB_INIT_CYCLES - 1;
      m_stall = 0; m_flush = 0; m_run = 0; m_cnt_known = 1'b1;
    end else begin
      case (m_mode)
        M_INIT: if (m_init_left == 0) m_mode = M_RUN; else m_init_left--;
        M_RUN: begin
          if (stall && m_stall < CMAX) m_stall++;
          if (redirect && m_flush < CMAX) m_flush++;
          if (m_run < CMAX) m_run++;
          if (!redirect && !stall && halt_id) m_mode = M_HALT;
        end
        default: if (resume) m_mode = M_RUN;
      endcase
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then take the edge.
  task automatic cycle(input string tag, input logic rst, input logic mb, input logic jr,
                       input logic bt, input logic lu, input logic hl, input logic rs);
    @(negedge clk);
    reset = rst; mem_busy = mb; jump_reg_ex = jr; branch_taken_ex = bt;
    load_use_id = lu; halt_id = hl; resume = rs;
    #1;
    check({tag, ".outs"},
          {22'd0, load_pc, branch_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, halted},
          {22'd0, expected_outputs()});
    check({tag, ".onehot"}, {31'd0, $onehot(branch_sel)}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    if (m_cnt_known) begin
      check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
      check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, m_flush);
      check({tag, ".run_cnt"},   {28'd0, run_cnt},   m_run);
    end
`endif
    advance_model();
    @(posedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset 3 cycles, INIT 2 cycles, then RUN.
    for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("init", 2);
    idle("run_start", 2);

    // Single taken branch, then sequential fetch.
    cycle("branch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("after_branch", 1);

    // Jump + branch together, then with memory busy.
    cycle("jr_and_br", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("busy_masks", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("after_busy", 1);

    // Two-cycle load-use bubble.
    cycle("load_use", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("load_use", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("after_lu", 1);

    // Redirect overrides a wrong-path halt.
    cycle("br_over_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("no_halt", 1);

    // Halt, 10 cycles of ignored inputs, resume.
    cycle("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle("halted", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b0);
    cycle("resume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("after_resume", 1);

    // Halt again, then reset mid-HALT.
    cycle("halt2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("halted2", 3);
    cycle("reset_in_halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("reinit", 4);

    // Long memory-busy run to saturate the stall counter, then reset.
    for (int i = 0; i < 20; i++) cycle("busy_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("stall_saturated", {28'd0, stall_cnt}, 32'd15);
`endif
    cycle("reset_cnt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("cnt_cleared", {20'd0, stall_cnt, flush_cnt, run_cnt}, 32'd0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      cycle("rand", 1'(($urandom % 64) == 0), 1'(($urandom % 6) == 0), 1'(($urandom % 8) == 0),
            1'(($urandom % 6) == 0), 1'(($urandom % 6) == 0), 1'(($urandom % 10) == 0),
            1'(($urandom % 6) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
